// File: rtl/sweep_ctrl.sv
// sweep_ctrl: frequency-sweep sequencer for the sine generator datapath.
// It steps the generator phase increment from a start value to a stop value.
// Each value is held for dwell+1 cycles. Sweeps run single-shot or continuously.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        request a sweep (sampled only in IDLE)
//   abort        terminate a sweep (sampled only in RUN)
//   cont         1 = continuous (wrap to start), 0 = single-shot; latched on start
//   incr_start   first increment value; latched on start
//   incr_stop    final increment value; latched on start
//   incr_step    step magnitude; latched on start
//   dwell        each value is held dwell+1 cycles; latched on start
//   gen_en       generator enable
//   gen_incr     generator phase increment
//   busy         high while a sweep is running
//   done         one-cycle pulse at the end of a single-shot sweep
//   step_tick    one-cycle pulse in each cycle where gen_incr takes a new value
module sweep_ctrl #(
  parameter int D_WIDTH  = 8,
  parameter int DW_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                cont,
  input  logic [D_WIDTH-1:0]  incr_start,
  input  logic [D_WIDTH-1:0]  incr_stop,
  input  logic [D_WIDTH-1:0]  incr_step,
  input  logic [DW_WIDTH-1:0] dwell,
  output logic                gen_en,
  output logic [D_WIDTH-1:0]  gen_incr,
  output logic                busy,
  output logic                done,
  output logic                step_tick
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state;
  logic [DW_WIDTH-1:0] cnt;

  // Sweep configuration captured when a sweep is accepted.
  logic [D_WIDTH-1:0]  start_q;
  logic [D_WIDTH-1:0]  stop_q;
  logic [D_WIDTH-1:0]  step_q;
  logic [DW_WIDTH-1:0] dwell_q;
  logic                cont_q;
  logic                up_q;

  logic                accept;
  logic                dwell_end;
  logic                at_stop;
  logic [D_WIDTH-1:0]  nxt_incr;

  // Next value with clamping: the step is evaluated one bit wider so that a
  // carry or borrow is seen as passing the stop value. A zero step jumps
  // straight to the stop value.
  function automatic logic [D_WIDTH-1:0] sat_next(
    input logic [D_WIDTH-1:0] cur,
    input logic [D_WIDTH-1:0] step,
    input logic [D_WIDTH-1:0] stop,
    input logic               up
  );
    logic [D_WIDTH:0]   wide;
    logic [D_WIDTH-1:0] res;
    res  = stop;
    wide = '0;
    if (up) begin
      wide = {1'b0, cur} + {1'b0, step};
      if (step != '0 && !wide[D_WIDTH] && wide[D_WIDTH-1:0] <= stop)
        res = wide[D_WIDTH-1:0];
    end else begin
      wide = {1'b0, cur} - {1'b0, step};
      if (step != '0 && !wide[D_WIDTH] && wide[D_WIDTH-1:0] >= stop)
        res = wide[D_WIDTH-1:0];
    end
    return res;
  endfunction

  assign accept    = (state == S_IDLE) && start;
  assign dwell_end = (cnt >= dwell_q);
  assign at_stop   = (gen_incr == stop_q);
  assign nxt_incr  = sat_next(gen_incr, step_q, stop_q, up_q);

  // Configuration holds only data, so it carries no reset; it is always
  // written before it is used.
  always_ff @(posedge clk) begin
    if (accept) begin
      start_q <= incr_start;
      stop_q  <= incr_stop;
      step_q  <= incr_step;
      dwell_q <= dwell;
      cont_q  <= cont;
      up_q    <= (incr_stop >= incr_start);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      gen_en    <= 1'b0;
      gen_incr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step_tick <= 1'b0;
    end else begin
      done      <= 1'b0;
      step_tick <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            cnt       <= '0;
            gen_en    <= 1'b1;
            busy      <= 1'b1;
            gen_incr  <= incr_start;
            step_tick <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            // Abort takes priority over a sweep that completes on the same edge.
            state  <= S_IDLE;
            gen_en <= 1'b0;
            busy   <= 1'b0;
          end else if (!dwell_end) begin
            cnt <= cnt + 1'b1;
          end else if (at_stop) begin
            if (cont_q) begin
              cnt       <= '0;
              gen_incr  <= start_q;
              step_tick <= 1'b1;
            end else begin
              state  <= S_DONE;
              gen_en <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end else begin
            cnt       <= '0;
            gen_incr  <= nxt_incr;
            step_tick <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          gen_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
module tb_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        cont;
  logic [7:0]  incr_start;
  logic [7:0]  incr_stop;
  logic [7:0]  incr_step;
  logic [15:0] dwell;
  logic        gen_en;
  logic [7:0]  gen_incr;
  logic        busy;
  logic        done;
  logic        step_tick;

  int checks   = 0;
  int failures = 0;

  sweep_ctrl #(.D_WIDTH(8), .DW_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cont       (cont),
    .incr_start (incr_start),
    .incr_stop  (incr_stop),
    .incr_step  (incr_step),
    .dwell      (dwell),
    .gen_en     (gen_en),
    .gen_incr   (gen_incr),
    .busy       (busy),
    .done       (done),
    .step_tick  (step_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare all outputs for the current cycle.
  task automatic expect_out(input string tag, input int c, input logic en, input int incr,
                            input logic bz, input logic dn, input logic tk);
    check($sformatf("%s_c%0d_en", tag, c),   32'(gen_en),    32'(en));
    check($sformatf("%s_c%0d_incr", tag, c), 32'(gen_incr),  32'(incr));
    check($sformatf("%s_c%0d_busy", tag, c), 32'(busy),      32'(bz));
    check($sformatf("%s_c%0d_done", tag, c), 32'(done),      32'(dn));
    check($sformatf("%s_c%0d_tick", tag, c), 32'(step_tick), 32'(tk));
  endtask

  // Called just after a falling edge: start is taken at the next rising edge
  // (edge 0) and the task returns at the sampling point of cycle 1.
  task automatic launch(input logic [7:0] s, input logic [7:0] p, input logic [7:0] st,
                        input logic [15:0] dw, input logic c);
    incr_start = s;
    incr_stop  = p;
    incr_step  = st;
    dwell      = dw;
    cont       = c;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0;
    incr_start = '0; incr_stop = '0; incr_step = '0; dwell = '0;
    repeat (3) @(negedge clk);
    expect_out("reset", 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    expect_out("idle", 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Basic up sweep, dwell 2: value changes every third cycle.
    launch(8'd10, 8'd40, 8'd10, 16'd2, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      expect_out("up", c, 1'b1, 10 * ((c - 1) / 3 + 1), 1'b1, 1'b0, ((c - 1) % 3) == 0);
    end
    @(negedge clk);
    expect_out("up", 13, 1'b0, 40, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    expect_out("up", 14, 1'b0, 40, 1'b0, 1'b0, 1'b0);

    // Overflow clamp: 250, 254, then 258 wraps and is clamped to 255.
    launch(8'd250, 8'd255, 8'd4, 16'd0, 1'b0);
    expect_out("ovf", 1, 1'b1, 250, 1'b1, 1'b0, 1'b1);
    @(negedge clk); expect_out("ovf", 2, 1'b1, 254, 1'b1, 1'b0, 1'b1);
    @(negedge clk); expect_out("ovf", 3, 1'b1, 255, 1'b1, 1'b0, 1'b1);
    @(negedge clk); expect_out("ovf", 4, 1'b0, 255, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Down sweep with clamp at 100 (80 would pass the stop value).
    launch(8'd200, 8'd100, 8'd60, 16'd1, 1'b0);
    expect_out("down", 1, 1'b1, 200, 1'b1, 1'b0, 1'b1);
    @(negedge clk); expect_out("down", 2, 1'b1, 200, 1'b1, 1'b0, 1'b0);
    @(negedge clk); expect_out("down", 3, 1'b1, 140, 1'b1, 1'b0, 1'b1);
    @(negedge clk); expect_out("down", 4, 1'b1, 140, 1'b1, 1'b0, 1'b0);
    @(negedge clk); expect_out("down", 5, 1'b1, 100, 1'b1, 1'b0, 1'b1);
    @(negedge clk); expect_out("down", 6, 1'b1, 100, 1'b1, 1'b0, 1'b0);
    @(negedge clk); expect_out("down", 7, 1'b0, 100, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Continuous sweep, then abort while gen_incr is 1.
    launch(8'd0, 8'd2, 8'd1, 16'd0, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      expect_out("cont", c, 1'b1, (c - 1) % 3, 1'b1, 1'b0, 1'b1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    expect_out("abort", 9, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("abort", 10, 1'b0, 1, 1'b0, 1'b0, 1'b0);

    // Abort on the same edge as the last-step completion: no done pulse.
    launch(8'd1, 8'd2, 8'd1, 16'd0, 1'b0);
    expect_out("abl", 1, 1'b1, 1, 1'b1, 1'b0, 1'b1);
    @(negedge clk); expect_out("abl", 2, 1'b1, 2, 1'b1, 1'b0, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    expect_out("abl", 3, 1'b0, 2, 1'b0, 1'b0, 1'b0);

    // start and config changes mid-sweep are ignored.
    launch(8'd20, 8'd50, 8'd10, 16'd1, 1'b0);
    expect_out("ign", 1, 1'b1, 20, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    expect_out("ign", 2, 1'b1, 20, 1'b1, 1'b0, 1'b0);
    start = 1'b1; incr_stop = 8'd21; incr_start = 8'd0; incr_step = 8'd1;
    @(negedge clk);
    start = 1'b0;
    expect_out("ign", 3, 1'b1, 30, 1'b1, 1'b0, 1'b1);
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      expect_out("ign", c, 1'b1, 10 * ((c - 1) / 2 + 2), 1'b1, 1'b0, (c % 2) == 1);
    end
    @(negedge clk); expect_out("ign", 9, 1'b0, 50, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // start == stop with abort asserted in IDLE: start accepted, single value.
    abort = 1'b1;
    launch(8'd77, 8'd77, 8'd5, 16'd0, 1'b0);
    abort = 1'b0;
    expect_out("same", 1, 1'b1, 77, 1'b1, 1'b0, 1'b1);
    @(negedge clk); expect_out("same", 2, 1'b0, 77, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Reset during RUN, then a fresh sweep.
    launch(8'd5, 8'd100, 8'd5, 16'd3, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      expect_out("rsr", c, 1'b1, (c <= 4) ? 5 : 10, 1'b1, 1'b0, (c == 1) || (c == 5));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_out("rsr", 6, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("rsr", 7, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    launch(8'd3, 8'd9, 8'd3, 16'd0, 1'b0);
    expect_out("post", 1, 1'b1, 3, 1'b1, 1'b0, 1'b1);
    @(negedge clk); expect_out("post", 2, 1'b1, 6, 1'b1, 1'b0, 1'b1);
    @(negedge clk); expect_out("post", 3, 1'b1, 9, 1'b1, 1'b0, 1'b1);
    @(negedge clk); expect_out("post", 4, 1'b0, 9, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
